// File: rtl/switch_traffic_stats.sv
// Per-port accepted/dropped/delivered packet-copy counters plus a global in-flight count,
// with sticky saturation/underflow flags and a one-cycle registered read port.
module switch_traffic_stats #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned PEND_WIDTH = 18,
    localparam int unsigned PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_PORTS-1:0]           valid_in,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] target_in,
    input  logic [NUM_PORTS-1:0]           fifo_full,
    input  logic [NUM_PORTS-1:0]           valid_out,
    input  logic                           clr,
    input  logic                           rd_en,
    input  logic [PORT_W-1:0]              rd_port,
    input  logic [1:0]                     rd_sel,
    output logic                           rd_valid,
    output logic [PEND_WIDTH-1:0]          rd_data,
    output logic [NUM_PORTS-1:0]           sat_flag,
    output logic                           underflow
);

    localparam int unsigned CW = $clog2(NUM_PORTS + 1);
    localparam int unsigned SW = $clog2(NUM_PORTS * NUM_PORTS + 1);
    localparam int unsigned XW = CNT_WIDTH + CW;
    localparam int unsigned EW = PEND_WIDTH + SW + 1;
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [PEND_WIDTH-1:0] PEND_MAX = {PEND_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0]  acc_q  [NUM_PORTS];
    logic [CNT_WIDTH-1:0]  acc_d  [NUM_PORTS];
    logic [CNT_WIDTH-1:0]  drop_q [NUM_PORTS];
    logic [CNT_WIDTH-1:0]  drop_d [NUM_PORTS];
    logic [CNT_WIDTH-1:0]  dlv_q  [NUM_PORTS];
    logic [CNT_WIDTH-1:0]  dlv_d  [NUM_PORTS];
    logic [PEND_WIDTH-1:0] pend_q, pend_d;
    logic [NUM_PORTS-1:0]  sat_q, sat_d;
    logic                  under_q, under_d;
    logic                  rd_valid_q;
    logic [PEND_WIDTH-1:0] rd_data_q, rd_mux;
    logic [SW-1:0]         add_sum, sub_sum;
    logic [EW-1:0]         pend_ext, pend_sub;

    // Returns {hit_max, saturated_sum}.
    function automatic logic [CNT_WIDTH:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic [CW-1:0]        inc);
        logic [XW-1:0] sum;
        sum = XW'(cnt) + XW'(inc);
        if (sum >= XW'(CNT_MAX)) begin
            return {1'b1, CNT_MAX};
        end
        return {1'b0, sum[CNT_WIDTH-1:0]};
    endfunction

    always_comb begin : next_state
        logic [CW-1:0]      copies;
        logic [CNT_WIDTH:0] r;
        acc_d    = acc_q;
        drop_d   = drop_q;
        dlv_d    = dlv_q;
        sat_d    = sat_q;
        under_d  = under_q;
        add_sum  = '0;
        sub_sum  = '0;
        copies   = '0;
        r        = '0;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            copies = '0;
            for (int b = 0; b < int'(NUM_PORTS); b++) begin
                copies = copies + CW'(target_in[p*int'(NUM_PORTS) + b]);
            end
            if (valid_in[p] && !fifo_full[p]) begin
                r        = sat_add(acc_q[p], copies);
                acc_d[p] = r[CNT_WIDTH-1:0];
                sat_d[p] = sat_d[p] | r[CNT_WIDTH];
                add_sum  = add_sum + SW'(copies);
            end
            if (valid_in[p] && fifo_full[p]) begin
                r         = sat_add(drop_q[p], copies);
                drop_d[p] = r[CNT_WIDTH-1:0];
                sat_d[p]  = sat_d[p] | r[CNT_WIDTH];
            end
            if (valid_out[p]) begin
                r        = sat_add(dlv_q[p], CW'(1));
                dlv_d[p] = r[CNT_WIDTH-1:0];
                sat_d[p] = sat_d[p] | r[CNT_WIDTH];
                sub_sum  = sub_sum + SW'(1);
            end
        end
        // Net in-flight change is applied once, so clamping sees the whole cycle's traffic.
        pend_ext = EW'(pend_q) + EW'(add_sum);
        pend_sub = '0;
        if (pend_ext < EW'(sub_sum)) begin
            pend_d  = '0;
            under_d = 1'b1;
        end else begin
            pend_sub = pend_ext - EW'(sub_sum);
            if (pend_sub > EW'(PEND_MAX)) begin
                pend_d = PEND_MAX;
            end else begin
                pend_d = pend_sub[PEND_WIDTH-1:0];
            end
        end
    end

    always_comb begin : read_mux
        rd_mux = '0;
        if (rd_sel == 2'd3) begin
            rd_mux = pend_q;
        end else begin
            for (int p = 0; p < int'(NUM_PORTS); p++) begin
                if (rd_port == PORT_W'(p)) begin
                    case (rd_sel)
                        2'd0:    rd_mux = PEND_WIDTH'(acc_q[p]);
                        2'd1:    rd_mux = PEND_WIDTH'(drop_q[p]);
                        2'd2:    rd_mux = PEND_WIDTH'(dlv_q[p]);
                        default: rd_mux = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin : counters
        if (!rst_n || clr) begin
            for (int p = 0; p < int'(NUM_PORTS); p++) begin
                acc_q[p]  <= '0;
                drop_q[p] <= '0;
                dlv_q[p]  <= '0;
            end
            pend_q  <= '0;
            sat_q   <= '0;
            under_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            drop_q  <= drop_d;
            dlv_q   <= dlv_d;
            pend_q  <= pend_d;
            sat_q   <= sat_d;
            under_q <= under_d;
        end
    end

    // Read path ignores clr so a read issued alongside clr returns pre-clear state.
    always_ff @(posedge clk) begin : read_pipe
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= rd_mux;
            end
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign sat_flag  = sat_q;
    assign underflow = under_q;

endmodule

// File: tb/tb_switch_traffic_stats.sv
// Directed bench for switch_traffic_stats: main instance plus a narrow-counter instance
// for saturation and a 3-port instance for out-of-range read ports.
module tb_switch_traffic_stats;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, clr, rd_en;
    logic [1:0] rd_port, rd_sel;

    logic [3:0]  a_vin, a_full, a_vout, a_sat;
    logic [15:0] a_tgt;
    logic        a_rv, a_unf;
    logic [17:0] a_rd;

    logic [3:0]  b_vin, b_zero, b_sat;
    logic [15:0] b_tgt;
    logic        b_rv, b_unf;
    logic [5:0]  b_rd;

    logic [2:0] c_vin, c_zero, c_sat;
    logic [8:0] c_tgt;
    logic       c_rv, c_unf;
    logic [9:0] c_rd;

    switch_traffic_stats #(.NUM_PORTS(4), .CNT_WIDTH(16), .PEND_WIDTH(18)) dut_a (
        .clk(clk), .rst_n(rst_n), .valid_in(a_vin), .target_in(a_tgt), .fifo_full(a_full),
        .valid_out(a_vout), .clr(clr), .rd_en(rd_en), .rd_port(rd_port), .rd_sel(rd_sel),
        .rd_valid(a_rv), .rd_data(a_rd), .sat_flag(a_sat), .underflow(a_unf)
    );

    switch_traffic_stats #(.NUM_PORTS(4), .CNT_WIDTH(4), .PEND_WIDTH(6)) dut_b (
        .clk(clk), .rst_n(rst_n), .valid_in(b_vin), .target_in(b_tgt), .fifo_full(b_zero),
        .valid_out(b_zero), .clr(clr), .rd_en(rd_en), .rd_port(rd_port), .rd_sel(rd_sel),
        .rd_valid(b_rv), .rd_data(b_rd), .sat_flag(b_sat), .underflow(b_unf)
    );

    switch_traffic_stats #(.NUM_PORTS(3), .CNT_WIDTH(8), .PEND_WIDTH(10)) dut_c (
        .clk(clk), .rst_n(rst_n), .valid_in(c_vin), .target_in(c_tgt), .fifo_full(c_zero),
        .valid_out(c_zero), .clr(clr), .rd_en(rd_en), .rd_port(rd_port), .rd_sel(rd_sel),
        .rd_valid(c_rv), .rd_data(c_rd), .sat_flag(c_sat), .underflow(c_unf)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input string tag, input int dut, input int port, input int sel,
                            input logic [31:0] exp);
        logic [1:0] pv, sv;
        pv      = port[1:0];
        sv      = sel[1:0];
        rd_en   = 1'b1;
        rd_port = pv;
        rd_sel  = sv;
        tick();
        rd_en = 1'b0;
        case (dut)
            0: begin
                check_val({tag, "_valid"}, 32'(a_rv), 32'd1);
                check_val(tag, 32'(a_rd), exp);
            end
            1: begin
                check_val({tag, "_valid"}, 32'(b_rv), 32'd1);
                check_val(tag, 32'(b_rd), exp);
            end
            default: begin
                check_val({tag, "_valid"}, 32'(c_rv), 32'd1);
                check_val(tag, 32'(c_rd), exp);
            end
        endcase
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; rd_en = 1'b0; rd_port = '0; rd_sel = '0;
        a_vin = '0; a_full = '0; a_vout = '0; a_tgt = '0;
        b_vin = '0; b_zero = '0; b_tgt = '0;
        c_vin = '0; c_zero = '0; c_tgt = '0;
        tick();
        tick();
        check_val("rst_rd_valid", 32'(a_rv), 32'd0);
        check_val("rst_rd_data", 32'(a_rd), 32'd0);
        check_val("rst_sat", 32'(a_sat), 32'd0);
        check_val("rst_underflow", 32'(a_unf), 32'd0);
        rst_n = 1'b1;
        tick();

        // Saturation: 5 cycles x 4 copies on port3 of a 4-bit counter.
        b_vin = 4'b1000;
        b_tgt = 16'hF000;
        tick(); tick(); tick();
        check_val("b_sat_before_max", 32'(b_sat), 32'd0);
        tick(); tick();
        b_vin = '0;
        check_val("b_sat_port3", 32'(b_sat), 32'b1000);
        read_chk("b_acc3", 1, 3, 0, 32'd15);
        read_chk("b_pend", 1, 0, 3, 32'd20);

        // Out-of-range read port on a 3-port instance.
        c_vin = 3'b111;
        c_tgt = 9'h1FF;
        tick();
        c_vin = '0;
        read_chk("c_oob_port", 2, 3, 0, 32'd0);
        read_chk("c_acc2", 2, 2, 0, 32'd3);

        // Accept 2 copies for 3 cycles, then deliver 6.
        a_vin = 4'b0001;
        a_tgt = 16'h0006;
        tick(); tick(); tick();
        a_vin = '0; a_tgt = '0;
        read_chk("t1_acc0", 0, 0, 0, 32'd6);
        read_chk("t1_pend", 0, 0, 3, 32'd6);
        a_vout = 4'b0110;
        tick(); tick(); tick();
        a_vout = '0;
        read_chk("t1_dlv1", 0, 1, 2, 32'd3);
        read_chk("t1_dlv2", 0, 2, 2, 32'd3);
        read_chk("t1_pend0", 0, 3, 3, 32'd0);
        check_val("t1_no_underflow", 32'(a_unf), 32'd0);

        // Dropped packet on port2 leaves accept and pending untouched.
        a_vin = 4'b0100; a_full = 4'b0100; a_tgt = 16'h0B00;
        tick();
        a_vin = '0; a_full = '0; a_tgt = '0;
        read_chk("t2_drop2", 0, 2, 1, 32'd3);
        read_chk("t2_acc2", 0, 2, 0, 32'd0);
        read_chk("t2_pend", 0, 0, 3, 32'd0);

        // All ports accept 4 copies while 2 deliveries occur: +16 -2.
        a_vin = 4'b1111; a_tgt = 16'hFFFF; a_vout = 4'b0011;
        tick();
        a_vin = '0; a_tgt = '0; a_vout = '0;
        read_chk("t3_pend", 0, 0, 3, 32'd14);
        read_chk("t3_acc1", 0, 1, 0, 32'd4);
        read_chk("t3_dlv0", 0, 0, 2, 32'd1);

        // Underflow: clear, then deliver with nothing in flight.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        read_chk("t4_pend_clr", 0, 0, 3, 32'd0);
        read_chk("t4_acc1_clr", 0, 1, 0, 32'd0);
        a_vout = 4'b0010;
        tick();
        a_vout = '0;
        check_val("t4_underflow", 32'(a_unf), 32'd1);
        read_chk("t4_pend_clamp", 0, 0, 3, 32'd0);
        read_chk("t4_dlv1", 0, 1, 2, 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_val("t4_underflow_clr", 32'(a_unf), 32'd0);
        check_val("a_sat_none", 32'(a_sat), 32'd0);

        // Read concurrent with clr returns pre-clear value; rd_data then holds.
        a_vin = 4'b0001; a_tgt = 16'h0007;
        tick();
        a_vin = '0; a_tgt = '0;
        rd_en = 1'b1; rd_sel = 2'd3; rd_port = 2'd2; clr = 1'b1;
        tick();
        rd_en = 1'b0; clr = 1'b0;
        check_val("t6_clr_read_valid", 32'(a_rv), 32'd1);
        check_val("t6_clr_read_data", 32'(a_rd), 32'd3);
        tick();
        check_val("t6_idle_valid", 32'(a_rv), 32'd0);
        check_val("t6_idle_hold", 32'(a_rd), 32'd3);
        read_chk("t6_after_clr", 0, 0, 3, 32'd0);

        // Read in the strobe cycle sees the value before that update.
        a_vin = 4'b0001; a_tgt = 16'h0001;
        read_chk("lat_same_cycle", 0, 0, 0, 32'd0);
        a_vin = 4'b0001; a_tgt = 16'h0000;
        tick();
        a_vin = '0;
        read_chk("lat_next_and_zero_mask", 0, 0, 0, 32'd1);

        // Reset during a read drops it.
        rd_en = 1'b1; rd_sel = 2'd0; rd_port = 2'd0; rst_n = 1'b0;
        tick();
        rd_en = 1'b0; rst_n = 1'b1;
        check_val("rst_mid_read_valid", 32'(a_rv), 32'd0);
        check_val("rst_mid_read_data", 32'(a_rd), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
